sdram_responder: RTL and testbench

SDRAM_RESPONDER -- requirements
Module: sdram_responder

---
 rtl/sdram_pkg.sv | 51 +++++
 rtl/sdram_resp_bank.sv | 47 ++++
 rtl/sdram_responder.sv | 187 ++++++++++++++++++
 tb/tb_sdram_responder.sv | 321 ++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/sdram_pkg.sv
// Shared SDRAM definitions: command encodings, mode-register field
// positions, legal CAS latencies and the read-return beat format.
// Used by both the SDRAM controller and the SDRAM responder model.
package sdram_pkg;

  // Command as {cs, ras, cas, we}. Anything with cs high decodes as inhibit.
  typedef enum logic [3:0] {
    CMD_INHIBIT   = 4'b1111,
    CMD_NOP       = 4'b0111,
    CMD_ACTIVE    = 4'b0011,
    CMD_READ      = 4'b0101,
    CMD_WRITE     = 4'b0100,
    CMD_BST       = 4'b0110,
    CMD_PRECHARGE = 4'b0010,
    CMD_REFRESH   = 4'b0001,
    CMD_LOAD_MODE = 4'b0000
  } sdram_cmd_e;

  // Mode-register field positions.
  localparam int MR_BL_LSB = 0;
  localparam int MR_BL_MSB = 2;
  localparam int MR_CL_LSB = 4;
  localparam int MR_CL_MSB = 6;

  // Legal field values: CAS latency 2 or 3, burst length 1.
  localparam logic [2:0] CL_2 = 3'd2;
  localparam logic [2:0] CL_3 = 3'd3;
  localparam logic [2:0] BL_1 = 3'b000;

  // Address bit that selects auto-precharge / precharge-all.
  localparam int A_AP = 10;

  // One read-return slot: lane enables plus masked data.
  typedef struct packed {
    logic        valid;
    logic [1:0]  oe;
    logic [15:0] data;
  } rd_beat_t;

  function automatic sdram_cmd_e decode_cmd(input logic cs, input logic ras,
                                            input logic cas, input logic we);
    // With cs low all eight encodings are defined commands.
    if (cs) return CMD_INHIBIT;
    return sdram_cmd_e'({1'b0, ras, cas, we});
  endfunction

  function automatic logic cl_legal(input logic [2:0] cl);
    return (cl == CL_2) || (cl == CL_3);
  endfunction

endpackage

// File: rtl/sdram_resp_bank.sv
// Per-bank state of the SDRAM responder: open flag, latched row and a
// saturating counter of cycles since the last ACTIVE. Only the row bits
// that address the backing array are kept; the upper row bits alias.
module sdram_resp_bank #(
  parameter int ROW_W = 3,
  parameter int TRCD  = 2
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             i_activate,
  input  logic [ROW_W-1:0] i_row,
  input  logic             i_close,
  output logic             o_open,
  output logic [ROW_W-1:0] o_row,
  output logic             o_trcd_met
);

  localparam int             CNT_W   = (TRCD < 2) ? 1 : $clog2(TRCD + 1);
  localparam logic [CNT_W-1:0] CNT_SAT = CNT_W'(TRCD);

  logic             r_open;
  logic [ROW_W-1:0] r_row;
  logic [CNT_W-1:0] r_cnt;

  // Open/close tracking and the tRCD counter; ACTIVE wins over a close.
  // NOTE: sequential state uses non-blocking assignments so every register
  // samples pre-edge values, matching the flop behaviour synthesis builds.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_open <= 1'b0;
      r_row  <= '0;
      r_cnt  <= CNT_SAT;
    end else if (i_activate) begin
      r_open <= 1'b1;
      r_row  <= i_row;
      r_cnt  <= CNT_W'(1);
    end else begin
      if (i_close) r_open <= 1'b0;
      if (r_cnt < CNT_SAT) r_cnt <= r_cnt + CNT_W'(1);
    end
  end

  assign o_open     = r_open;
  assign o_row      = r_row;
  assign o_trcd_met = (r_cnt >= CNT_SAT);

endmodule

// File: rtl/sdram_responder.sv
// Behavioural SDRAM device model for controller testing: decodes commands,
// keeps four banks, a 16-bit backing array and a CAS-latency read pipeline.
// Protocol/timing checking is compiled in with macro SDRAM_RESP_CHECK_EN;
// without it err_proto and err_timing stay at their reset value of 0.
module sdram_responder
  import sdram_pkg::*;
#(
  parameter int MEM_AW = 14,
  parameter int COL_W  = 9,
  parameter int TRCD   = 2
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        sd_cs,
  input  logic        sd_ras,
  input  logic        sd_cas,
  input  logic        sd_we,
  input  logic [1:0]  sd_ba,
  input  logic [12:0] sd_addr,
  input  logic [1:0]  sd_dqm,
  input  logic [15:0] sd_data_in,
  output logic [15:0] sd_data_out,
  output logic [1:0]  sd_data_oe,
  output logic [12:0] mode_reg,
  output logic        init_done,
  output logic        err_proto,
  output logic        err_timing
);

  localparam int ROW_W = MEM_AW - 2 - COL_W;

`ifdef SDRAM_RESP_CHECK_EN
  localparam bit CHECK_EN = 1'b1;
`else
  localparam bit CHECK_EN = 1'b0;
`endif

  sdram_cmd_e       w_cmd;
  logic             w_is_rd;
  logic             w_is_wr;
  logic             w_act;
  logic             w_rw_req;
  logic             w_rw_hit;
  logic             w_sel_open;
  logic [ROW_W-1:0] w_sel_row;
  logic             w_sel_trcd;
  logic [3:0]       w_bank_open;
  logic [3:0]       w_trcd_met;
  logic [3:0]       w_bank_act;
  logic [3:0]       w_bank_close;
  logic [ROW_W-1:0] w_bank_row [4];
  logic [MEM_AW-1:0] w_mem_addr;
  logic [15:0]      w_rd_word;
  rd_beat_t         w_rd_beat;
  logic             w_cl3;
  logic             w_in_flight;
  logic             w_proto_ev;
  logic             w_timing_ev;

  logic [15:0]      r_mem [2**MEM_AW];
  rd_beat_t         r_pipe [3];
  logic [12:0]      r_mode;
  logic             r_init_done;
  logic             r_err_proto;
  logic             r_err_timing;

  assign w_cmd      = decode_cmd(sd_cs, sd_ras, sd_cas, sd_we);
  assign w_is_rd    = (w_cmd == CMD_READ);
  assign w_is_wr    = (w_cmd == CMD_WRITE);
  assign w_sel_open = w_bank_open[sd_ba];
  assign w_sel_row  = w_bank_row[sd_ba];
  assign w_sel_trcd = w_trcd_met[sd_ba];

  // Commands other than NOP/PRECHARGE/REFRESH/LOAD_MODE are ignored until
  // the mode register has been loaded; accesses to a closed bank are dropped.
  assign w_act    = (w_cmd == CMD_ACTIVE) && r_init_done;
  assign w_rw_req = (w_is_rd || w_is_wr) && r_init_done;
  assign w_rw_hit = w_rw_req && w_sel_open;

  // Per-bank activate and close strobes (PRECHARGE or auto-precharge).
  // NOTE: combinational blocks assign every output a default first so no
  // path leaves a value held, which would otherwise infer a latch.
  always_comb begin
    w_bank_act   = '0;
    w_bank_close = '0;
    for (int b = 0; b < 4; b++) begin
      w_bank_act[b]   = w_act && (sd_ba == 2'(b));
      w_bank_close[b] = ((w_cmd == CMD_PRECHARGE) && (sd_addr[A_AP] || (sd_ba == 2'(b))))
                     || (w_rw_hit && sd_addr[A_AP] && (sd_ba == 2'(b)));
    end
  end

  for (genvar gi = 0; gi < 4; gi++) begin : g_bank
    sdram_resp_bank #(
      .ROW_W(ROW_W),
      .TRCD (TRCD)
    ) u_bank (
      .clk       (clk),
      .reset     (reset),
      .i_activate(w_bank_act[gi]),
      .i_row     (sd_addr[ROW_W-1:0]),
      .i_close   (w_bank_close[gi]),
      .o_open    (w_bank_open[gi]),
      .o_row     (w_bank_row[gi]),
      .o_trcd_met(w_trcd_met[gi])
    );
  end

  assign w_mem_addr = {sd_ba, w_sel_row, sd_addr[COL_W-1:0]};
  assign w_rd_word  = r_mem[w_mem_addr];

  // Byte-masked write into the backing array on the WRITE edge.
  // NOTE: the array is deliberately left out of reset; it models DRAM
  // contents that survive a controller reset and maps onto plain RAM.
  always_ff @(posedge clk) begin
    if (w_rw_hit && w_is_wr) begin
      if (!sd_dqm[0]) r_mem[w_mem_addr][7:0]  <= sd_data_in[7:0];
      if (!sd_dqm[1]) r_mem[w_mem_addr][15:8] <= sd_data_in[15:8];
    end
  end

  // Read beat formed at the READ edge; masked lanes carry zero and no enable.
  always_comb begin
    w_rd_beat       = '0;
    w_rd_beat.valid = 1'b1;
    w_rd_beat.oe    = ~sd_dqm;
    w_rd_beat.data  = {sd_dqm[1] ? 8'h00 : w_rd_word[15:8],
                       sd_dqm[0] ? 8'h00 : w_rd_word[7:0]};
  end

  // Three-slot shift pipeline; slot k holds a read issued k+1 edges ago.
  always_ff @(posedge clk) begin
    if (reset) begin
      for (int i = 0; i < 3; i++) r_pipe[i] <= '0;
    end else begin
      r_pipe[0] <= (w_rw_hit && w_is_rd) ? w_rd_beat : '0;
      r_pipe[1] <= r_pipe[0];
      r_pipe[2] <= r_pipe[1];
    end
  end

  // CL=3 drives from the last slot, anything else is treated as CL=2.
  assign w_cl3       = (r_mode[MR_CL_MSB:MR_CL_LSB] == CL_3);
  assign sd_data_out = w_cl3 ? r_pipe[2].data : r_pipe[1].data;
  assign sd_data_oe  = w_cl3 ? r_pipe[2].oe   : r_pipe[1].oe;

  // A read counts as in flight until its beat has finished on the bus.
  assign w_in_flight = r_pipe[0].valid || r_pipe[1].valid || (w_cl3 && r_pipe[2].valid);

  // Mode register and init flag; a LOAD_MODE always latches.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_mode      <= '0;
      r_init_done <= 1'b0;
    end else if (w_cmd == CMD_LOAD_MODE) begin
      r_mode      <= sd_addr;
      r_init_done <= 1'b1;
    end
  end

  assign w_proto_ev =
       (!r_init_done && (w_cmd inside {CMD_ACTIVE, CMD_READ, CMD_WRITE, CMD_BST}))
    || (w_act && w_sel_open)
    || (w_rw_req && !w_sel_open)
    || ((w_cmd == CMD_REFRESH) && (|w_bank_open))
    || ((w_cmd == CMD_LOAD_MODE) && (!cl_legal(sd_addr[MR_CL_MSB:MR_CL_LSB])
                                     || (sd_addr[MR_BL_MSB:MR_BL_LSB] != BL_1)
                                     || (|w_bank_open) || w_in_flight));
  assign w_timing_ev = w_rw_hit && !w_sel_trcd;

  // Sticky error flags; with checking compiled out they never leave 0.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_err_proto  <= 1'b0;
      r_err_timing <= 1'b0;
    end else if (CHECK_EN) begin
      r_err_proto  <= r_err_proto  | w_proto_ev;
      r_err_timing <= r_err_timing | w_timing_ev;
    end
  end

  assign mode_reg   = r_mode;
  assign init_done  = r_init_done;
  assign err_proto  = r_err_proto;
  assign err_timing = r_err_timing;

endmodule

// File: tb/tb_sdram_responder.sv
// Scoreboard bench for sdram_responder: directed scenarios followed by
// randomized command streams, checked against a command-level device model.
module tb_sdram_responder;

  localparam int MEM_AW = 14;
  localparam int COL_W  = 9;
  localparam int TRCD   = 2;
  localparam int ROW_W  = MEM_AW - 2 - COL_W;

`ifdef SDRAM_RESP_CHECK_EN
  localparam bit CHK = 1'b1;
`else
  localparam bit CHK = 1'b0;
`endif

  localparam logic [3:0] C_INH = 4'b1111;
  localparam logic [3:0] C_NOP = 4'b0111;
  localparam logic [3:0] C_ACT = 4'b0011;
  localparam logic [3:0] C_RD  = 4'b0101;
  localparam logic [3:0] C_WR  = 4'b0100;
  localparam logic [3:0] C_BST = 4'b0110;
  localparam logic [3:0] C_PRE = 4'b0010;
  localparam logic [3:0] C_REF = 4'b0001;
  localparam logic [3:0] C_LMR = 4'b0000;

  logic        clk;
  logic        reset;
  logic        sd_cs, sd_ras, sd_cas, sd_we;
  logic [1:0]  sd_ba;
  logic [12:0] sd_addr;
  logic [1:0]  sd_dqm;
  logic [15:0] sd_data_in;
  logic [15:0] sd_data_out;
  logic [1:0]  sd_data_oe;
  logic [12:0] mode_reg;
  logic        init_done;
  logic        err_proto;
  logic        err_timing;

  sdram_responder #(
    .MEM_AW(MEM_AW),
    .COL_W (COL_W),
    .TRCD  (TRCD)
  ) dut (
    .clk        (clk),
    .reset      (reset),
    .sd_cs      (sd_cs),
    .sd_ras     (sd_ras),
    .sd_cas     (sd_cas),
    .sd_we      (sd_we),
    .sd_ba      (sd_ba),
    .sd_addr    (sd_addr),
    .sd_dqm     (sd_dqm),
    .sd_data_in (sd_data_in),
    .sd_data_out(sd_data_out),
    .sd_data_oe (sd_data_oe),
    .mode_reg   (mode_reg),
    .init_done  (init_done),
    .err_proto  (err_proto),
    .err_timing (err_timing)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int edge_cnt = 0;
  always @(posedge clk) edge_cnt <= edge_cnt + 1;

  int total = 0;
  int bad   = 0;
  int rst_edge = 32'h7fffffff;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h (edge %0d)", name, act, exp, edge_cnt);
    end
  endtask

  // ---------------- reference model ----------------
  typedef struct {
    int          due;   // edge after which the beat is on the bus
    logic [1:0]  oe;
    logic [15:0] data;
    logic [15:0] care;
  } exp_t;

  exp_t        sb[$];
  logic [15:0] m_mem   [int];
  logic [1:0]  m_known [int];
  bit          m_open [4];
  int          m_row  [4];
  int          m_act  [4];
  logic [12:0] m_mode;
  bit          m_init;
  bit          m_proto;
  bit          m_timing;
  int          m_last_due;

  task automatic model_apply(input int t, input bit rst, input logic [3:0] c,
                             input logic [1:0] ba, input logic [12:0] addr,
                             input logic [1:0] dqm, input logic [15:0] din);
    int b, idx, cl;
    bit any_open;
    logic [15:0] cur;
    logic [1:0]  kn;
    exp_t e;
    b = int'(ba);
    if (rst) begin
      for (int i = 0; i < 4; i++) begin
        m_open[i] = 0; m_row[i] = 0; m_act[i] = -1000;
      end
      m_mode = '0; m_init = 0; m_proto = 0; m_timing = 0; m_last_due = -1000;
      while (sb.size() > 0 && sb[$].due >= t) void'(sb.pop_back());
      if (rst_edge > t) rst_edge = t;
      return;
    end
    any_open = m_open[0] || m_open[1] || m_open[2] || m_open[3];
    cl = (m_mode[6:4] == 3'd3) ? 3 : 2;
    if (c[3]) return;
    case (c)
      C_BST: if (!m_init) m_proto = 1;
      C_ACT: begin
        if (!m_init) m_proto = 1;
        else begin
          if (m_open[b]) m_proto = 1;
          m_open[b] = 1; m_row[b] = int'(addr); m_act[b] = t;
        end
      end
      C_RD, C_WR: begin
        if (!m_init || !m_open[b]) m_proto = 1;
        else begin
          if (t - m_act[b] < TRCD) m_timing = 1;
          idx = b * (2 ** (ROW_W + COL_W)) + (m_row[b] % (2 ** ROW_W)) * (2 ** COL_W)
              + (int'(addr) % (2 ** COL_W));
          cur = m_mem.exists(idx) ? m_mem[idx] : 16'h0000;
          kn  = m_known.exists(idx) ? m_known[idx] : 2'b00;
          if (c == C_WR) begin
            for (int l = 0; l < 2; l++)
              if (!dqm[l]) begin
                cur[l*8 +: 8] = din[l*8 +: 8];
                kn[l] = 1'b1;
              end
            m_mem[idx] = cur; m_known[idx] = kn;
          end else begin
            e.due = t + cl - 1; e.oe = 2'b00; e.data = '0; e.care = '0;
            for (int l = 0; l < 2; l++) begin
              if (dqm[l]) e.care[l*8 +: 8] = 8'hFF;
              else begin
                e.oe[l] = 1'b1;
                if (kn[l]) begin
                  e.data[l*8 +: 8] = cur[l*8 +: 8];
                  e.care[l*8 +: 8] = 8'hFF;
                end
              end
            end
            sb.push_back(e);
            m_last_due = e.due;
          end
          if (addr[10]) m_open[b] = 0;
        end
      end
      C_PRE: begin
        if (addr[10]) for (int i = 0; i < 4; i++) m_open[i] = 0;
        else m_open[b] = 0;
      end
      C_REF: if (any_open) m_proto = 1;
      C_LMR: begin
        if (any_open || (m_last_due >= t - 1) || !(addr[6:4] == 3'd2 || addr[6:4] == 3'd3)
            || (addr[2:0] != 3'b000)) m_proto = 1;
        m_mode = addr; m_init = 1;
      end
      default: ;
    endcase
  endtask

  // ---------------- driver ----------------
  task automatic step(input bit rst, input logic [3:0] c, input logic [1:0] ba,
                      input logic [12:0] addr, input logic [1:0] dqm, input logic [15:0] din);
    @(negedge clk);
    if (edge_cnt >= rst_edge) begin
      check("err_proto",  {31'b0, err_proto},  {31'b0, CHK & m_proto});
      check("err_timing", {31'b0, err_timing}, {31'b0, CHK & m_timing});
      check("init_done",  {31'b0, init_done},  {31'b0, m_init});
      check("mode_reg",   {19'b0, mode_reg},   {19'b0, m_mode});
    end
    reset = rst;
    {sd_cs, sd_ras, sd_cas, sd_we} = c;
    sd_ba = ba; sd_addr = addr; sd_dqm = dqm; sd_data_in = din;
    model_apply(edge_cnt + 1, rst, c, ba, addr, dqm, din);
  endtask

  task automatic rst_cyc();  step(1'b1, C_NOP, 2'd0, 13'd0, 2'b00, 16'h0); endtask
  task automatic nop();      step(1'b0, C_NOP, 2'd0, 13'd0, 2'b00, 16'h0); endtask
  task automatic act(input logic [1:0] ba, input logic [12:0] row);
    step(1'b0, C_ACT, ba, row, 2'b00, 16'h0);
  endtask
  task automatic rd(input logic [1:0] ba, input logic [8:0] col, input bit ap, input logic [1:0] dqm);
    step(1'b0, C_RD, ba, {2'b00, ap, 1'b0, col}, dqm, 16'h0);
  endtask
  task automatic wr(input logic [1:0] ba, input logic [8:0] col, input bit ap,
                    input logic [1:0] dqm, input logic [15:0] d);
    step(1'b0, C_WR, ba, {2'b00, ap, 1'b0, col}, dqm, d);
  endtask
  task automatic pre(input logic [1:0] ba, input bit all);
    step(1'b0, C_PRE, ba, {2'b00, all, 10'd0}, 2'b00, 16'h0);
  endtask
  task automatic lmr(input logic [12:0] m); step(1'b0, C_LMR, 2'd0, m, 2'b00, 16'h0); endtask

  // ---------------- monitor ----------------
  always @(negedge clk) begin
    exp_t b;
    if (edge_cnt >= rst_edge) begin
      if (sb.size() > 0 && sb[0].due < edge_cnt) begin
        b = sb.pop_front();
        check("rd_missed_slot", 32'(b.due), 32'(edge_cnt));
      end
      if (sb.size() > 0 && sb[0].due == edge_cnt) begin
        b = sb.pop_front();
        check("rd_oe",   {30'b0, sd_data_oe}, {30'b0, b.oe});
        check("rd_data", {16'b0, sd_data_out & b.care}, {16'b0, b.data & b.care});
      end else begin
        check("idle_oe",   {30'b0, sd_data_oe}, 32'd0);
        check("idle_data", {16'b0, sd_data_out}, 32'd0);
      end
    end
  end

  // ---------------- stimulus ----------------
  task automatic rand_cmd();
    int r;
    logic [1:0]  ba;
    logic [12:0] ra;
    bit ap;
    r  = $urandom_range(0, 99);
    ba = 2'($urandom);
    ap = ($urandom_range(0, 3) == 0);
    ra = {2'($urandom), ap, 1'($urandom), 7'd0, 2'($urandom)};
    if (r < 20)      nop();
    else if (r < 23) step(1'b0, {1'b1, 3'($urandom)}, ba, 13'($urandom), 2'($urandom), 16'($urandom));
    else if (r < 36) act(ba, 13'($urandom));
    else if (r < 60) step(1'b0, C_RD, ba, ra, 2'($urandom), 16'($urandom));
    else if (r < 82) step(1'b0, C_WR, ba, ra, 2'($urandom), 16'($urandom));
    else if (r < 90) pre(ba, ($urandom_range(0, 2) == 0));
    else if (r < 94) step(1'b0, C_REF, ba, 13'd0, 2'b00, 16'h0);
    else if (r < 96) step(1'b0, C_BST, ba, 13'd0, 2'b00, 16'h0);
    else             step(1'b0, C_INH, ba, 13'd0, 2'b00, 16'h0);
  endtask

  initial begin
    reset = 1'b1;
    {sd_cs, sd_ras, sd_cas, sd_we} = C_INH;
    sd_ba = '0; sd_addr = '0; sd_dqm = '0; sd_data_in = '0;

    // Reset and initialisation with CL=3.
    rst_cyc(); rst_cyc();
    nop();
    pre(2'd0, 1'b1);
    lmr(13'h0230);
    nop();

    // Write with auto-precharge, reopen, read back at CL=3.
    act(2'd1, 13'd5); nop(); nop();
    wr(2'd1, 9'd3, 1'b1, 2'b00, 16'hA55A);
    act(2'd1, 13'd5); nop(); nop();
    rd(2'd1, 9'd3, 1'b0, 2'b00);
    nop(); nop(); nop(); nop();

    // Byte masks on write and read.
    act(2'd2, 13'd1); nop(); nop();
    wr(2'd2, 9'd7, 1'b0, 2'b00, 16'hFFFF);
    wr(2'd2, 9'd7, 1'b0, 2'b01, 16'h1234);
    rd(2'd2, 9'd7, 1'b0, 2'b00);
    rd(2'd2, 9'd7, 1'b0, 2'b10);
    nop(); nop(); nop(); nop();

    // Early READ after ACTIVE, then READ to a closed bank.
    pre(2'd0, 1'b1);
    act(2'd0, 13'd2); nop(); nop();
    wr(2'd0, 9'd3, 1'b1, 2'b00, 16'hBEEF);
    act(2'd0, 13'd2);
    rd(2'd0, 9'd3, 1'b0, 2'b00);
    nop(); nop(); nop();
    pre(2'd0, 1'b1);
    rd(2'd3, 9'd1, 1'b0, 2'b00);
    nop(); nop(); nop(); nop();

    // CL=2: back-to-back reads, illegal LOAD_MODE, reset mid-pipeline.
    rst_cyc();
    pre(2'd0, 1'b1);
    lmr(13'h0220);
    act(2'd1, 13'd5); nop(); nop();
    for (int i = 0; i < 4; i++) wr(2'd1, 9'(i), 1'b0, 2'b00, 16'h1000 + 16'(i * 17));
    for (int i = 0; i < 4; i++) rd(2'd1, 9'(i), 1'b0, 2'b00);
    nop(); nop(); nop(); nop();
    lmr(13'h0220);
    rd(2'd1, 9'd0, 1'b0, 2'b00);
    rd(2'd1, 9'd1, 1'b0, 2'b00);
    rst_cyc();
    nop(); nop(); nop();
    lmr(13'h0221);
    nop();

    // Randomised rounds, each starting from reset with a random CL.
    for (int round = 0; round < 10; round++) begin
      rst_cyc();
      for (int i = 0; i < 4; i++) rand_cmd();
      pre(2'd0, 1'b1);
      lmr(($urandom_range(0, 1) == 0) ? 13'h0220 : 13'h0230);
      for (int i = 0; i < 300; i++) rand_cmd();
    end

    for (int i = 0; i < 8; i++) nop();
    @(negedge clk);
    check("scoreboard_drained", 32'(sb.size()), 32'd0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
